pipeline_hazard_controller: RTL and testbench

Sequences the 5-stage ARM64 pipeline by generating per-stage register enables and bubble inserts. It detects load-use hazards that forwarding cannot cover and freezes the pipeline while data memory inserts wait states. It sits beside the forwarding unit, observing decoded register fields in ID and control bits held in the ID/EX and EX/MA registers. It drives hold/bubble controls for the PC, IF/ID, ID/EX, EX/MA and WB registers.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/pipeline_hazard_controller_if.sv | 61 ++++++
 rtl/hazard_wait_timer.sv | 42 ++++
 rtl/pipeline_hazard_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   hazard_state_t : controller FSM state
//   reg_idx_t      : architectural register index (X0..X30, XZR)
//   XZR_IDX        : index of the zero register, never a hazard source
//   sat_inc32      : saturating 32-bit increment used by the stall counters
package hazard_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int unsigned XZR_IDX = 31;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    FAULT
  } hazard_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: pipeline observation fields in, stage controls out.
//   slave  : the hazard controller (reads ID/EX/MA fields, drives enables/bubbles)
//   master : the pipeline datapath (drives fields, consumes enables/bubbles)
// With HAZARD_PERF_COUNTERS_EN defined the bus also carries lu_stall_cnt and
// mem_stall_cnt from the controller.
interface pipeline_hazard_controller_if;
  import hazard_pkg::*;

  // ID stage
  reg_idx_t id_rn;
  reg_idx_t id_rb;
  logic     id_uses_rn;
  logic     id_uses_rb;
  logic     id_is_cbz;
  // EX stage
  reg_idx_t ex_rd;
  logic     ex_mem_read;
  logic     ex_reg_write;
  // MA stage / data memory
  logic     ma_mem_access;
  logic     dmem_ready;
  // Stage controls
  logic     pc_en;
  logic     if_id_en;
  logic     ex_ma_en;
  logic     id_ex_bubble;
  logic     wb_bubble;
  logic     stalled;
  logic     fault;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] lu_stall_cnt;
  logic [31:0] mem_stall_cnt;
`endif

`ifdef HAZARD_PERF_COUNTERS_EN
  modport slave (
    input  id_rn, id_rb, id_uses_rn, id_uses_rb, id_is_cbz,
    input  ex_rd, ex_mem_read, ex_reg_write, ma_mem_access, dmem_ready,
    output pc_en, if_id_en, ex_ma_en, id_ex_bubble, wb_bubble, stalled, fault,
    output lu_stall_cnt, mem_stall_cnt
  );
  modport master (
    output id_rn, id_rb, id_uses_rn, id_uses_rb, id_is_cbz,
    output ex_rd, ex_mem_read, ex_reg_write, ma_mem_access, dmem_ready,
    input  pc_en, if_id_en, ex_ma_en, id_ex_bubble, wb_bubble, stalled, fault,
    input  lu_stall_cnt, mem_stall_cnt
  );
`else
  modport slave (
    input  id_rn, id_rb, id_uses_rn, id_uses_rb, id_is_cbz,
    input  ex_rd, ex_mem_read, ex_reg_write, ma_mem_access, dmem_ready,
    output pc_en, if_id_en, ex_ma_en, id_ex_bubble, wb_bubble, stalled, fault
  );
  modport master (
    output id_rn, id_rb, id_uses_rn, id_uses_rb, id_is_cbz,
    output ex_rd, ex_mem_read, ex_reg_write, ma_mem_access, dmem_ready,
    input  pc_en, if_id_en, ex_ma_en, id_ex_bubble, wb_bubble, stalled, fault
  );
`endif

endinterface

// File: rtl/hazard_wait_timer.sv
// Saturating 8-bit memory wait counter.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   clr_i     : clear the count (has priority over inc_i)
//   inc_i     : count one wait cycle
//   expired_o : the increment happening this cycle reaches MAX_WAIT
module hazard_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [8:0] Limit = 9'(MAX_WAIT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (inc_i && (count_q != 8'hff)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Looks one increment ahead so the FSM can leave MEM_WAIT on the edge the
  // count reaches MAX_WAIT.
  assign expired_o = ({1'b0, count_q} + 9'd1) >= Limit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage ARM64 pipeline: detects load-use and CBZ
// operand hazards, freezes the pipeline during data-memory wait states and
// raises a sticky fault when a memory access exceeds MAX_WAIT wait cycles.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-low reset
//   bus   : pipeline_hazard_controller_if.slave (ID/EX/MA fields in, stage
//           enables, bubbles, stalled and fault out)
// Optional: define HAZARD_PERF_COUNTERS_EN to add saturating stall counters
// (lu_stall_cnt, mem_stall_cnt) on the bus.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned ZERO_REG = XZR_IDX
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   bus
);

  localparam reg_idx_t ZeroIdx = reg_idx_t'(ZERO_REG);

  hazard_state_t state_q, state_d;

  logic lu_hazard;
  logic cbz_hazard;
  logic use_hazard;
  logic mem_wait;
  logic timer_expired;
  logic lu_stall;
  logic mem_stall;
  logic in_fault;

  always_comb begin
    lu_hazard  = bus.ex_mem_read & bus.ex_reg_write & (bus.ex_rd != ZeroIdx) &
                 ((bus.id_uses_rn & (bus.id_rn == bus.ex_rd)) |
                  (bus.id_uses_rb & (bus.id_rb == bus.ex_rd)));
    // CBZ tests its operand in ID, so even an ALU result in EX is too late.
    cbz_hazard = bus.id_is_cbz & bus.ex_reg_write & (bus.ex_rd == bus.id_rb) &
                 (bus.ex_rd != ZeroIdx);
    use_hazard = lu_hazard | cbz_hazard;
    mem_wait   = bus.ma_mem_access & ~bus.dmem_ready;
  end

  always_comb begin
    state_d   = state_q;
    lu_stall  = 1'b0;
    mem_stall = 1'b0;
    in_fault  = 1'b0;
    unique case (state_q)
      // LU_STALL only marks that the previous cycle stalled; decisions are
      // made exactly as in RUN so a persisting hazard stalls again.
      RUN, LU_STALL: begin
        if (mem_wait) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
        end else if (use_hazard) begin
          lu_stall = 1'b1;
          state_d  = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          mem_stall = 1'b1;
          if (timer_expired) begin
            state_d = FAULT;
          end
        end else if (use_hazard) begin
          // The access completes, but a hazard held behind it must still
          // bubble before ID is allowed to advance.
          lu_stall = 1'b1;
          state_d  = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FAULT: begin
        in_fault = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs read as the idle pattern while reset is held.
    if (!reset) begin
      state_d   = RUN;
      lu_stall  = 1'b0;
      mem_stall = 1'b0;
      in_fault  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (state_d != MEM_WAIT),
    .inc_i     (state_q == MEM_WAIT),
    .expired_o (timer_expired)
  );

  assign bus.pc_en        = ~(lu_stall | mem_stall | in_fault);
  assign bus.if_id_en     = ~(lu_stall | mem_stall | in_fault);
  assign bus.ex_ma_en     = ~(mem_stall | in_fault);
  assign bus.id_ex_bubble = lu_stall;
  assign bus.wb_bubble    = mem_stall | in_fault;
  assign bus.stalled      = lu_stall | mem_stall | in_fault;
  assign bus.fault        = in_fault;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;

  always_comb begin
    lu_cnt_d  = lu_stall ? sat_inc32(lu_cnt_q) : lu_cnt_q;
    mem_cnt_d = mem_stall ? sat_inc32(mem_cnt_q) : mem_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lu_cnt_q  <= 32'd0;
      mem_cnt_q <= 32'd0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign bus.lu_stall_cnt  = lu_cnt_q;
  assign bus.mem_stall_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int unsigned MaxWait = 4;

  // Output vector order: {pc_en, if_id_en, ex_ma_en, id_ex_bubble, wb_bubble, stalled, fault}
  localparam logic [6:0] ExpRun   = 7'b1110000;
  localparam logic [6:0] ExpLu    = 7'b0011010;
  localparam logic [6:0] ExpMem   = 7'b0000110;
  localparam logic [6:0] ExpFault = 7'b0000111;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller #(
    .MAX_WAIT (MaxWait),
    .ZERO_REG (31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whether a memory access is outstanding, how many
  // wait cycles it has burned after the first, and whether it timed out.
  bit          m_waiting;
  int unsigned m_waited;
  bit          m_faulted;
  int unsigned m_lu_cycles;
  int unsigned m_mem_cycles;

  function automatic logic [6:0] observed();
    return {bus.pc_en, bus.if_id_en, bus.ex_ma_en, bus.id_ex_bubble, bus.wb_bubble,
            bus.stalled, bus.fault};
  endfunction

  function automatic bit hazard_now();
    bit writes_real = bus.ex_reg_write && (bus.ex_rd != 5'd31);
    bit load_use = writes_real && bus.ex_mem_read &&
                   ((bus.id_uses_rn && bus.id_rn == bus.ex_rd) ||
                    (bus.id_uses_rb && bus.id_rb == bus.ex_rd));
    bit cbz_use = writes_real && bus.id_is_cbz && (bus.id_rb == bus.ex_rd);
    return load_use || cbz_use;
  endfunction

  function automatic bit mem_blocked();
    if (m_waiting) return !bus.dmem_ready;
    return bus.ma_mem_access && !bus.dmem_ready;
  endfunction

  function automatic logic [6:0] model_out();
    if (!reset) return ExpRun;
    if (m_faulted) return ExpFault;
    if (mem_blocked()) return ExpMem;
    if (hazard_now()) return ExpLu;
    return ExpRun;
  endfunction

  task automatic model_step();
    bit blocked;
    if (!reset) begin
      m_waiting = 0; m_waited = 0; m_faulted = 0; m_lu_cycles = 0; m_mem_cycles = 0;
    end else if (!m_faulted) begin
      blocked = mem_blocked();
      if (blocked) begin
        if (m_waiting) m_waited++;
        if (m_waited >= MaxWait) m_faulted = 1;
        m_waiting = 1;
        m_mem_cycles++;
      end else begin
        if (hazard_now()) m_lu_cycles++;
        m_waiting = 0;
        m_waited  = 0;
      end
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [4:0] rn, input logic [4:0] rb, input logic urn,
                       input logic urb, input logic cbz, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic ma, input logic rdy);
    bus.id_rn = rn; bus.id_rb = rb; bus.id_uses_rn = urn; bus.id_uses_rb = urb;
    bus.id_is_cbz = cbz; bus.ex_rd = rd; bus.ex_mem_read = mr; bus.ex_reg_write = rw;
    bus.ma_mem_access = ma; bus.dmem_ready = rdy;
  endtask

  task automatic drive_idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    next_edge();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    // Hazard and mem-wait both present: reset must still show the idle pattern.
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== ExpRun) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b want %b", i, observed(), ExpRun);
      end
      next_edge();
    end
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL after_reset: got %b want %b", observed(), ExpRun);
    end
    next_edge();
  endtask

  task automatic test_load_use();
    // LDUR X1 in EX, ADD X2,X1,X3 in ID
    drive(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (observed() !== ExpLu) begin
      errors++;
      $display("FAIL load_use_stall: got %b want %b", observed(), ExpLu);
    end
    next_edge();
    // Bubble now in EX
    drive(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL load_use_resume: got %b want %b", observed(), ExpRun);
    end
    next_edge();
    // LDUR X31 in EX, ID reads X31
    drive(5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL xzr_no_stall: got %b want %b", observed(), ExpRun);
    end
    next_edge();
  endtask

  task automatic test_back_to_back();
    // Hazard persists for two cycles (new load each time) -> two bubbles.
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== ExpLu) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, observed(), ExpLu);
      end
      next_edge();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL back_to_back_end: got %b want %b", observed(), ExpRun);
    end
    next_edge();
  endtask

  task automatic test_cbz();
    // ADD X4 in EX, CBZ X4 in ID
    drive(5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (observed() !== ExpLu) begin
      errors++;
      $display("FAIL cbz_stall: got %b want %b", observed(), ExpLu);
    end
    next_edge();
    // CBZ X5 instead
    drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL cbz_other_reg: got %b want %b", observed(), ExpRun);
    end
    next_edge();
  endtask

  task automatic test_mem_wait(input bit with_hazard);
    logic [6:0] want;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (with_hazard && cyc < 4)
        drive(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, cyc < 4, cyc >= 3);
      else
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, cyc < 4, cyc >= 3);
      if (cyc < 3) want = ExpMem;
      else if (cyc == 3 && with_hazard) want = ExpLu;
      else want = ExpRun;
      @(negedge clk);
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL mem_wait(hazard=%0d)[%0d]: got %b want %b", with_hazard, cyc,
                 observed(), want);
      end
      next_edge();
    end
  endtask

  task automatic test_fault();
    logic [6:0] want;
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // One detect cycle plus MaxWait waiting cycles, then FAULT.
    for (int cyc = 0; cyc < 8; cyc++) begin
      want = (cyc <= MaxWait) ? ExpMem : ExpFault;
      @(negedge clk);
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b want %b", cyc, observed(), want);
      end
      next_edge();
    end
    drive_idle();
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      checks++;
      if (observed() !== ExpFault) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: got %b want %b", cyc, observed(), ExpFault);
      end
      next_edge();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL fault_during_reset: got %b want %b", observed(), ExpRun);
    end
    next_edge();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== ExpRun) begin
      errors++;
      $display("FAIL fault_cleared: got %b want %b", observed(), ExpRun);
    end
    next_edge();
  endtask

`ifdef HAZARD_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
      next_edge();
      drive_idle();
      next_edge();
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, cyc >= 3);
      next_edge();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.lu_stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL lu_stall_cnt: got %0d want 2", bus.lu_stall_cnt);
    end
    checks++;
    if (bus.mem_stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL mem_stall_cnt: got %0d want 3", bus.mem_stall_cnt);
    end
    next_edge();
  endtask
`endif

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      default: return 5'd31;
    endcase
  endfunction

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), pick_reg(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)));
      want = model_out();
      @(negedge clk);
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b", cyc, observed(), want);
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      checks++;
      if (bus.lu_stall_cnt !== m_lu_cycles || bus.mem_stall_cnt !== m_mem_cycles) begin
        errors++;
        $display("FAIL random_counts[%0d]: got %0d/%0d want %0d/%0d", cyc,
                 bus.lu_stall_cnt, bus.mem_stall_cnt, m_lu_cycles, m_mem_cycles);
      end
`endif
      next_edge();
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_cbz();
    test_mem_wait(1'b0);
    test_mem_wait(1'b1);
    test_fault();
`ifdef HAZARD_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
